// File: rtl/axistream_unpack_keep.sv
// rtl/axistream_unpack_keep.sv - splits one wide keep-qualified beat into narrow words.
// Lanes whose keep bit is clear are skipped, and skipping them costs no cycles.
module axistream_unpack_keep #(
  parameter int DATA_WIDTH = 8,
  parameter int NUM_PACK   = 4,
  parameter bit BIG_ENDIAN = 1'b0
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             src_tvalid,
  output logic                             src_tready,
  input  logic [DATA_WIDTH*NUM_PACK-1:0]   src_tdata,
  input  logic [NUM_PACK-1:0]              src_tkeep,
  input  logic                             src_tlast,
  output logic                             dest_tvalid,
  input  logic                             dest_tready,
  output logic [DATA_WIDTH-1:0]            dest_tdata,
  output logic                             dest_tlast
);

  logic [DATA_WIDTH*NUM_PACK-1:0] data_q, data_d;
  logic [NUM_PACK-1:0]            mask_q, mask_d;
  logic                           last_q, last_d;
  logic [NUM_PACK-1:0]            sel_oh;
  logic                           found;
  logic                           final_lane;
  logic                           src_hs;
  logic                           dest_hs;
  int                             lane;

  // Choose the first remaining lane in emission order, as a one-hot vector.
  always_comb begin
    sel_oh = '0;
    found  = 1'b0;
    lane   = 0;
    for (int k = 0; k < NUM_PACK; k++) begin
      lane = BIG_ENDIAN ? (NUM_PACK - 1 - k) : k;
      if (!found && mask_q[lane]) begin
        sel_oh[lane] = 1'b1;
        found        = 1'b1;
      end
    end
  end

  always_comb begin
    dest_tdata = '0;
    for (int i = 0; i < NUM_PACK; i++) begin
      if (sel_oh[i]) begin
        dest_tdata = data_q[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  assign final_lane  = (mask_q != '0) && ((mask_q & (mask_q - NUM_PACK'(1))) == '0);
  assign dest_tvalid = (mask_q != '0) && !rst;
  assign dest_tlast  = dest_tvalid && last_q && final_lane;
  assign src_tready  = !rst && ((mask_q == '0) || (dest_tvalid && dest_tready && final_lane));
  assign src_hs      = src_tvalid && src_tready;
  assign dest_hs     = dest_tvalid && dest_tready;

  // A new beat may land on the same edge that retires the final lane.
  always_comb begin
    data_d = data_q;
    mask_d = mask_q;
    last_d = last_q;
    if (src_hs) begin
      data_d = src_tdata;
      mask_d = src_tkeep;
      last_d = src_tlast && (src_tkeep != '0);
    end else if (dest_hs) begin
      mask_d = mask_q & ~sel_oh;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      data_q <= '0;
      mask_q <= '0;
      last_q <= 1'b0;
    end else begin
      data_q <= data_d;
      mask_q <= mask_d;
      last_q <= last_d;
    end
  end

endmodule

// File: tb/tb_axistream_unpack_keep.sv
// tb/tb_axistream_unpack_keep.sv - bench for axistream_unpack_keep, both lane orders.
// A queue-based model of the words still owed predicts every output on every cycle.
module tb_axistream_unpack_keep;

  logic        clk = 1'b0;
  logic        rst;
  logic        src_tvalid;
  logic [31:0] src_tdata;
  logic [3:0]  src_tkeep;
  logic        src_tlast;
  logic        dest_tready;

  logic       le_src_tready, le_dest_tvalid, le_dest_tlast;
  logic [7:0] le_dest_tdata;
  logic       be_src_tready, be_dest_tvalid, be_dest_tlast;
  logic [7:0] be_dest_tdata;

  int n_checks = 0;
  int n_fail   = 0;

  logic [8:0] q_le[$];
  logic [8:0] q_be[$];
  logic       dr_pat[$];
  logic       dr_rand = 1'b0;

  always #5 clk = ~clk;

  axistream_unpack_keep #(.DATA_WIDTH(8), .NUM_PACK(4), .BIG_ENDIAN(1'b0)) u_dut_le (
    .clk(clk), .rst(rst),
    .src_tvalid(src_tvalid), .src_tready(le_src_tready),
    .src_tdata(src_tdata), .src_tkeep(src_tkeep), .src_tlast(src_tlast),
    .dest_tvalid(le_dest_tvalid), .dest_tready(dest_tready),
    .dest_tdata(le_dest_tdata), .dest_tlast(le_dest_tlast)
  );

  axistream_unpack_keep #(.DATA_WIDTH(8), .NUM_PACK(4), .BIG_ENDIAN(1'b1)) u_dut_be (
    .clk(clk), .rst(rst),
    .src_tvalid(src_tvalid), .src_tready(be_src_tready),
    .src_tdata(src_tdata), .src_tkeep(src_tkeep), .src_tlast(src_tlast),
    .dest_tvalid(be_dest_tvalid), .dest_tready(dest_tready),
    .dest_tdata(be_dest_tdata), .dest_tlast(be_dest_tlast)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive inputs, check against the model, advance the model.
  task automatic tick(input logic r, input logic tv, input logic [31:0] d,
                      input logic [3:0] k, input logic l, output logic acc);
    logic dr;
    logic exp_valid, exp_ready;
    int   nk, pushed;
    if (dr_pat.size() != 0) dr = dr_pat.pop_front();
    else if (dr_rand)       dr = 1'($urandom_range(0, 1));
    else                    dr = 1'b1;
    rst = r; src_tvalid = tv; src_tdata = d; src_tkeep = k; src_tlast = l; dest_tready = dr;
    #1;
    exp_valid = !r && (q_le.size() != 0);
    exp_ready = !r && ((q_le.size() == 0) || (dr && q_le.size() == 1));
    check("le_src_tready", 32'(le_src_tready), 32'(exp_ready));
    check("be_src_tready", 32'(be_src_tready), 32'(exp_ready));
    check("le_dest_tvalid", 32'(le_dest_tvalid), 32'(exp_valid));
    check("be_dest_tvalid", 32'(be_dest_tvalid), 32'(exp_valid));
    if (exp_valid) begin
      check("le_dest_tdata", 32'(le_dest_tdata), 32'(q_le[0][7:0]));
      check("le_dest_tlast", 32'(le_dest_tlast), 32'(q_le[0][8]));
      check("be_dest_tdata", 32'(be_dest_tdata), 32'(q_be[0][7:0]));
      check("be_dest_tlast", 32'(be_dest_tlast), 32'(q_be[0][8]));
    end else begin
      check("le_dest_tlast_idle", 32'(le_dest_tlast), 32'd0);
      check("be_dest_tlast_idle", 32'(be_dest_tlast), 32'd0);
    end
    acc = tv && exp_ready;
    if (r) begin
      q_le.delete();
      q_be.delete();
    end else begin
      if (exp_valid && dr) begin
        void'(q_le.pop_front());
        void'(q_be.pop_front());
      end
      if (acc) begin
        nk = $countones(k);
        pushed = 0;
        for (int i = 0; i < 4; i++) begin
          if (k[i]) begin
            q_le.push_back({l && (pushed == nk - 1), d[i*8 +: 8]});
            pushed++;
          end
        end
        pushed = 0;
        for (int i = 3; i >= 0; i--) begin
          if (k[i]) begin
            q_be.push_back({l && (pushed == nk - 1), d[i*8 +: 8]});
            pushed++;
          end
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic send_beat(input logic [31:0] d, input logic [3:0] k, input logic l);
    logic acc;
    int   n;
    acc = 1'b0;
    n = 0;
    while (!acc && n < 50) begin
      tick(1'b0, 1'b1, d, k, l, acc);
      n++;
    end
    check("send_beat_accepted", 32'(acc), 32'd1);
  endtask

  task automatic idle(input int n);
    logic acc;
    for (int i = 0; i < n; i++) begin
      tick(1'b0, 1'b0, $urandom, 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)), acc);
    end
  endtask

  initial begin
    logic acc;
    rst = 1'b1; src_tvalid = 1'b0; src_tdata = '0; src_tkeep = '0; src_tlast = 1'b0;
    dest_tready = 1'b1;
    @(posedge clk);
    #1;
    tick(1'b1, 1'b1, 32'h12345678, 4'hF, 1'b1, acc);
    tick(1'b1, 1'b0, 32'h0, 4'h0, 1'b0, acc);
    idle(1);

    send_beat(32'h44332211, 4'hF, 1'b1);
    idle(5);

    send_beat(32'hDDCCBBAA, 4'b1010, 1'b1);
    send_beat(32'h04030201, 4'hF, 1'b0);
    send_beat(32'h08070605, 4'hF, 1'b1);
    idle(9);

    dr_pat = '{1'b1, 1'b0, 1'b0, 1'b1};
    send_beat(32'hA4A3A2A1, 4'hF, 1'b1);
    idle(7);

    send_beat(32'hFFFFFFFF, 4'h0, 1'b1);
    send_beat(32'h04030201, 4'hF, 1'b0);
    idle(2);
    tick(1'b1, 1'b0, 32'h0, 4'h0, 1'b0, acc);
    idle(3);

    dr_rand = 1'b1;
    for (int b = 0; b < 300; b++) begin
      if ($urandom_range(0, 3) == 0) idle(int'($urandom_range(1, 2)));
      send_beat($urandom, 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
      if ($urandom_range(0, 40) == 0) tick(1'b1, 1'b1, $urandom, 4'hF, 1'b1, acc);
    end
    dr_rand = 1'b0;
    idle(8);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
